ftdi_bus_arbiter: RTL and testbench

//   Owns the half-duplex FT245 synchronous FIFO bus on clk_60; shares it between the RX path
//   (host->FPGA pixel stream feeding the BRAM sequencer) and a TX path (FPGA->host status bytes).

---
 rtl/ftdi_pkg.sv | 31 +++
 rtl/ftdi_burst_cnt.sv | 49 ++++
 rtl/ftdi_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_ftdi_bus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// ============================================================================
//  Package     : ftdi_pkg
//  Description : Shared definitions for the FT245 synchronous FIFO bus
//                arbiter: FSM state encodings, direction constants and
//                default burst sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ftdi_pkg;

  // Default burst sizing; the counter width must be able to hold MAX_BURST
  localparam int MAX_BURST_DEF = 64;
  localparam int BURST_W_DEF   = 7;

  typedef logic [2:0] state_t;

  // Arbiter FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RX_OE = 3'd1;
  localparam logic [2:0] ST_RX    = 3'd2;
  localparam logic [2:0] ST_TX    = 3'd3;
  localparam logic [2:0] ST_TURN  = 3'd4;

  // Grant direction, remembered across a turnaround for fair alternation
  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ftdi_burst_cnt.sv
// ============================================================================
//  Module      : ftdi_burst_cnt
//  Description : Per-grant byte counter. Clears synchronously, increments on
//                each transfer and saturates at MAX_BURST-1, where it raises
//                its terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftdi_burst_cnt #(
  parameter int MAX_BURST = 64,
  parameter int BURST_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [BURST_W-1:0] TC_VAL = BURST_W'(MAX_BURST - 1);

  logic [BURST_W-1:0] cnt_q;
  logic [BURST_W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Next count: clear wins, otherwise count transfers and hold at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ftdi_bus_arbiter.sv
// ============================================================================
//  Module      : ftdi_bus_arbiter
//  Description : Owns the half-duplex FT245 synchronous FIFO bus. Shares it
//                between the host->FPGA RX stream and the FPGA->host TX
//                stream with bounded bursts, strobe sequencing and a
//                one-cycle turnaround between every grant.
//  Config      : define FTDI_TX_EN to build the TX path; without it the
//                arbiter is RX-only and the TX outputs are held inactive.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ftdi_bus_arbiter
  import ftdi_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BURST_W   = BURST_W_DEF
) (
  input  logic       clk_60,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       rxf_n,
  input  logic       txe_n,
  output logic       oe_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  state_t state_q, state_d;
  logic   cur_dir_q, cur_dir_d;
  logic   last_dir_q, last_dir_d;

  logic   w_rx_req;
  logic   w_tx_req;
  logic   w_tc;
  logic   w_in_rx;
  logic   w_in_tx;

  assign w_rx_req = !rxf_n && rx_ready;
  assign w_in_rx  = (state_q == ST_RX);

  // All bus outputs decode from the registered state, so an async reset
  // releases every strobe and the bus in the same cycle it is asserted.
  assign oe_n     = !((state_q == ST_RX_OE) || w_in_rx);
  assign rd_n     = !w_in_rx;
  assign rx_valid = w_in_rx && !rxf_n;
  assign rx_data  = data_in;

`ifdef FTDI_TX_EN
  assign w_tx_req = !txe_n && tx_valid;
  assign w_in_tx  = (state_q == ST_TX);
  assign data_oe  = w_in_tx;
  assign wr_n     = !(w_in_tx && tx_valid);
  assign tx_ready = w_in_tx && tx_valid && !txe_n;
  assign data_out = tx_data;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_valid, txe_n};
  assign w_tx_req  = 1'b0;
  assign w_in_tx   = 1'b0;
  assign data_oe   = 1'b0;
  assign wr_n      = 1'b1;
  assign tx_ready  = 1'b0;
  assign data_out  = 8'h00;
`endif

  // Per-grant byte counter, held clear whenever no grant is active
  ftdi_burst_cnt #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_burst_cnt (
    .clk   (clk_60),
    .rst_n (rst_n),
    .clr_i (!(w_in_rx || w_in_tx)),
    .en_i  (rx_valid || tx_ready),
    .tc_o  (w_tc)
  );

  // Arbitration and bus sequencing: grant, burst, turnaround
  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    last_dir_d = last_dir_q;
    case (state_q)
      ST_IDLE: begin
        // With both requesting, the direction not served last wins
        if (w_rx_req && (!w_tx_req || (last_dir_q == DIR_TX))) begin
          state_d   = ST_RX_OE;
          cur_dir_d = DIR_RX;
        end else if (w_tx_req) begin
          state_d   = ST_TX;
          cur_dir_d = DIR_TX;
        end
      end
      ST_RX_OE: state_d = ST_RX;
      ST_RX: begin
        if (rxf_n || !rx_ready || (rx_valid && w_tc)) begin
          state_d = ST_TURN;
        end
      end
`ifdef FTDI_TX_EN
      ST_TX: begin
        if (txe_n || !tx_valid || (tx_ready && w_tc)) begin
          state_d = ST_TURN;
        end
      end
`endif
      ST_TURN: begin
        last_dir_d = cur_dir_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and direction history registers
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_dir_q  <= DIR_TX;
      last_dir_q <= DIR_TX;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      last_dir_q <= last_dir_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ftdi_bus_arbiter.sv
// ============================================================================
//  Module      : tb_ftdi_bus_arbiter
//  Description : Directed self-checking bench for ftdi_bus_arbiter with
//                MAX_BURST=4. Status vector per cycle is
//                {oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ftdi_bus_arbiter;

  localparam logic [5:0] IDL = 6'b111000;  // idle / turnaround
  localparam logic [5:0] OE  = 6'b011000;  // RX output-enable cycle
  localparam logic [5:0] RXV = 6'b001010;  // RX, byte accepted
  localparam logic [5:0] RXN = 6'b001000;  // RX, FIFO empty
  localparam logic [5:0] TXV = 6'b110101;  // TX, byte transferred
  localparam logic [5:0] TXS = 6'b110100;  // TX, FTDI full
  localparam logic [5:0] TXI = 6'b111100;  // TX, nothing pending

  logic       clk_60 = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       rxf_n;
  logic       txe_n;
  logic       oe_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] rx_src   = 8'h01;  // next byte the modelled FTDI presents
  logic [7:0] rx_exp   = 8'h01;  // next byte the bench expects delivered
  logic [7:0] tx_src   = 8'h00;  // next byte the modelled source offers
  logic [7:0] tx_exp   = 8'h00;  // next byte the bench expects sent

  always #5 clk_60 = ~clk_60;

  ftdi_bus_arbiter #(
    .MAX_BURST (4),
    .BURST_W   (3)
  ) dut (
    .clk_60   (clk_60),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .rxf_n    (rxf_n),
    .txe_n    (txe_n),
    .oe_n     (oe_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: apply inputs after the edge, check, then take the edge
  task automatic cyc(input string tag, input logic rxf, input logic txe,
                     input logic rdy, input logic tv, input logic [5:0] exp);
    logic obs_rv;
    logic obs_tr;
    rxf_n    = rxf;
    txe_n    = txe;
    rx_ready = rdy;
    tx_valid = tv;
    data_in  = rx_src;
    tx_data  = tx_src;
    #1;
    chk(tag, {26'd0, oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready}, {26'd0, exp});
    chk({tag, "_excl"}, {31'd0, data_oe & ~oe_n}, 32'd0);
    if (exp[1]) begin
      chk({tag, "_rxd"}, {24'd0, rx_data}, {24'd0, rx_exp});
      rx_exp = rx_exp + 8'd1;
    end
    if (exp[0]) begin
      chk({tag, "_txd"}, {24'd0, data_out}, {24'd0, tx_exp});
      tx_exp = tx_exp + 8'd1;
    end
    obs_rv = rx_valid;
    obs_tr = tx_ready;
    @(posedge clk_60);
    if (obs_rv) rx_src = rx_src + 8'd1;
    if (obs_tr) tx_src = tx_src + 8'd1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rxf_n    = 1'b1;
    txe_n    = 1'b1;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    data_in  = 8'h00;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk_60);
    #1;
    chk("reset", {26'd0, oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready}, {26'd0, IDL});
    rst_n = 1'b1;

    // RX only: three bytes, then FIFO empties
    cyc("a0", 1'b0, 1'b1, 1'b1, 1'b0, IDL);
    cyc("a1", 1'b0, 1'b1, 1'b1, 1'b0, OE);
    cyc("a2", 1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("a3", 1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("a4", 1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("a5", 1'b1, 1'b1, 1'b1, 1'b0, RXN);
    cyc("a6", 1'b1, 1'b1, 1'b1, 1'b0, IDL);
    cyc("a7", 1'b1, 1'b1, 1'b1, 1'b0, IDL);

    // Burst limit of 4, regrant, then backpressure mid-burst
    cyc("b0",  1'b0, 1'b1, 1'b1, 1'b0, IDL);
    cyc("b1",  1'b0, 1'b1, 1'b1, 1'b0, OE);
    cyc("b2",  1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("b3",  1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("b4",  1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("b5",  1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("b6",  1'b0, 1'b1, 1'b1, 1'b0, IDL);
    cyc("b7",  1'b0, 1'b1, 1'b1, 1'b0, IDL);
    cyc("b8",  1'b0, 1'b1, 1'b1, 1'b0, OE);
    cyc("b9",  1'b0, 1'b1, 1'b1, 1'b0, RXV);
    cyc("b10", 1'b0, 1'b1, 1'b0, 1'b0, RXV);
    cyc("b11", 1'b0, 1'b1, 1'b0, 1'b0, IDL);
    cyc("b12", 1'b0, 1'b1, 1'b0, 1'b0, IDL);
    cyc("b13", 1'b1, 1'b1, 1'b1, 1'b0, IDL);

`ifdef FTDI_TX_EN
    // Contention (last grant was RX, so TX first), then TX stall and resume
    cyc("c0",  1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c1",  1'b0, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c2",  1'b0, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c3",  1'b0, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c4",  1'b0, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c5",  1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c6",  1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c7",  1'b0, 1'b0, 1'b1, 1'b1, OE);
    cyc("c8",  1'b0, 1'b0, 1'b1, 1'b1, RXV);
    cyc("c9",  1'b0, 1'b0, 1'b1, 1'b1, RXV);
    cyc("c10", 1'b0, 1'b0, 1'b1, 1'b1, RXV);
    cyc("c11", 1'b0, 1'b0, 1'b1, 1'b1, RXV);
    cyc("c12", 1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c13", 1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c14", 1'b0, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c15", 1'b1, 1'b1, 1'b1, 1'b1, TXS);
    cyc("c16", 1'b1, 1'b1, 1'b1, 1'b1, IDL);
    cyc("c17", 1'b1, 1'b1, 1'b1, 1'b1, IDL);
    cyc("c18", 1'b1, 1'b0, 1'b1, 1'b1, IDL);
    cyc("c19", 1'b1, 1'b0, 1'b1, 1'b1, TXV);
    cyc("c20", 1'b1, 1'b0, 1'b1, 1'b0, TXI);
    cyc("c21", 1'b1, 1'b0, 1'b1, 1'b0, IDL);
    chk("tx_total", {24'd0, tx_src}, 32'd6);
`else
    // RX-only build: TX requests are ignored, RX still served
    cyc("n0", 1'b1, 1'b0, 1'b1, 1'b1, IDL);
    cyc("n1", 1'b1, 1'b0, 1'b1, 1'b1, IDL);
    chk("n_dout", {24'd0, data_out}, 32'd0);
    cyc("n2", 1'b0, 1'b0, 1'b1, 1'b1, IDL);
    cyc("n3", 1'b0, 1'b0, 1'b1, 1'b1, OE);
    cyc("n4", 1'b0, 1'b0, 1'b1, 1'b1, RXV);
    cyc("n5", 1'b1, 1'b0, 1'b1, 1'b1, RXN);
    cyc("n6", 1'b1, 1'b0, 1'b1, 1'b1, IDL);
    cyc("n7", 1'b1, 1'b1, 1'b1, 1'b0, IDL);
`endif

    // Asynchronous reset in the middle of an RX burst
    cyc("d0", 1'b0, 1'b1, 1'b1, 1'b0, IDL);
    cyc("d1", 1'b0, 1'b1, 1'b1, 1'b0, OE);
    cyc("d2", 1'b0, 1'b1, 1'b1, 1'b0, RXV);
    rxf_n   = 1'b0;
    data_in = rx_src;
    #1;
    chk("d3_pre", {26'd0, oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready}, {26'd0, RXV});
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {26'd0, oe_n, rd_n, wr_n, data_oe, rx_valid, tx_ready}, {26'd0, IDL});
    @(posedge clk_60);
    #1;
    rst_n = 1'b1;
    cyc("d4", 1'b1, 1'b1, 1'b1, 1'b0, IDL);
    cyc("d5", 1'b1, 1'b1, 1'b1, 1'b0, IDL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
